// File: rtl/core_pkg.sv
// Shared types for the 8085-class core sequencer: T-state codes, machine-cycle codes, decode-hint bit positions.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package core_pkg;

    localparam int TSTSIZE  = 3;
    localparam int MCYSIZE  = 2;
    localparam int INSTSIZE = 2;

    // Bit positions inside chk_inst
    localparam int INST_GO6 = 0;
    localparam int INST_DAD = 1;

    typedef enum logic [TSTSIZE-1:0] {
        T1   = 3'd0,
        T2   = 3'd1,
        T3   = 3'd2,
        T4   = 3'd3,
        T5   = 3'd4,
        T6   = 3'd5,
        TW   = 3'd6,
        HALT = 3'd7
    } tstate_t;

    typedef enum logic [MCYSIZE-1:0] {
        MC_FETCH = 2'd0,
        MC_READ  = 2'd1,
        MC_IDLE  = 2'd2,
        MC_HALT  = 2'd3
    } mcycle_t;

endpackage

// File: rtl/core_seq_if.sv
// Sequencer <-> datapath/bus bundle: ready and decode hints in, strobes, enables and cycle status out.
// Latency: n/a (wiring only).
// Backpressure: ready stretches bus cycles with wait states; no other flow control.
// Ports: master = sequencer side, slave = datapath/bus side.
interface core_seq_if #(
    parameter int TSTSIZE  = core_pkg::TSTSIZE,
    parameter int MCYSIZE  = core_pkg::MCYSIZE,
    parameter int INSTSIZE = core_pkg::INSTSIZE
);
    logic                ready;
    logic [INSTSIZE-1:0] chk_inst;
    logic                op_imm;
    logic                op_halt;
    logic                ale;
    logic                rd_n;
    logic                enb_code;
    logic                enb_data;
    logic                enb_rreg;
    logic                enb_wreg;
    logic [TSTSIZE-1:0]  t_state;
    logic [MCYSIZE-1:0]  m_cycle;

    modport master (
        input  ready, chk_inst, op_imm, op_halt,
        output ale, rd_n, enb_code, enb_data, enb_rreg, enb_wreg, t_state, m_cycle
    );

    modport slave (
        output ready, chk_inst, op_imm, op_halt,
        input  ale, rd_n, enb_code, enb_data, enb_rreg, enb_wreg, t_state, m_cycle
    );
endinterface

// File: rtl/core_seq.sv
// T-state / machine-cycle sequencer: opcode fetch (4/6 T), immediate read (3 T), two DAD bus-idle cycles, HALT.
// Latency: outputs are combinational from state registers (enb_rreg also from decode hints in T4/T6).
// Backpressure: ready=0 sampled at end of T2/TW inserts one TW per sample in fetch/read cycles.
// Ports: clk, rst_n (async active-low), bus (core_seq_if.master).
module core_seq
    import core_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    core_seq_if.master  bus
);

    tstate_t state_q, state_d;
    mcycle_t mcyc_q,  mcyc_d;
    logic    bi_cnt_q, bi_cnt_d;
    logic    wb_pend_q, wb_pend_d;

    logic go6, dad, imm, hlt;
    assign go6 = bus.chk_inst[INST_GO6];
    assign dad = bus.chk_inst[INST_DAD];
    assign imm = bus.op_imm;
    assign hlt = bus.op_halt;

    // Opcode fetch is complete when leaving T4 without GO6, or leaving T6.
    logic m1_done;
    assign m1_done = (state_q == T6) || ((state_q == T4) && !go6);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= T1;
            mcyc_q    <= MC_FETCH;
            bi_cnt_q  <= 1'b0;
            wb_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcyc_q    <= mcyc_d;
            bi_cnt_q  <= bi_cnt_d;
            wb_pend_q <= wb_pend_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        mcyc_d    = mcyc_q;
        bi_cnt_d  = bi_cnt_q;
        wb_pend_d = wb_pend_q;
        case (state_q)
            T1: begin
                state_d = T2;
                // The write-back overlapping this fetch T1 is now done.
                if (mcyc_q == MC_FETCH) wb_pend_d = 1'b0;
            end
            T2: begin
                // Bus-idle cycles do not access memory, so ready is irrelevant there.
                if (mcyc_q == MC_IDLE || bus.ready) state_d = T3;
                else                                 state_d = TW;
            end
            TW: begin
                state_d = bus.ready ? T3 : TW;
            end
            T3: begin
                case (mcyc_q)
                    MC_FETCH: state_d = T4;
                    MC_READ: begin
                        state_d   = T1;
                        mcyc_d    = MC_FETCH;
                        wb_pend_d = 1'b1;
                    end
                    MC_IDLE: begin
                        state_d = T1;
                        if (!bi_cnt_q) begin
                            bi_cnt_d = 1'b1;
                        end else begin
                            bi_cnt_d  = 1'b0;
                            mcyc_d    = MC_FETCH;
                            wb_pend_d = 1'b1;
                        end
                    end
                    default: state_d = state_q;
                endcase
            end
            T4: begin
                if (go6) state_d = T5;
            end
            T5: state_d = T6;
            T6: state_d = T6;
            HALT: state_d = HALT;
            default: state_d = T1;
        endcase

        // Dispatch after the opcode fetch; priority halt > imm > dad.
        if (m1_done) begin
            if (hlt) begin
                state_d   = HALT;
                mcyc_d    = MC_HALT;
                wb_pend_d = 1'b0;
            end else if (imm) begin
                state_d = T1;
                mcyc_d  = MC_READ;
            end else if (dad) begin
                state_d  = T1;
                mcyc_d   = MC_IDLE;
                bi_cnt_d = 1'b0;
            end else begin
                state_d   = T1;
                mcyc_d    = MC_FETCH;
                wb_pend_d = 1'b1;
            end
        end
    end

    // Output decode
    logic ale_c, rd_c, code_c, data_c, rreg_c, wreg_c, mem_c;
    always_comb begin
        ale_c  = 1'b0;
        rd_c   = 1'b0;
        code_c = 1'b0;
        data_c = 1'b0;
        rreg_c = 1'b0;
        wreg_c = 1'b0;
        mem_c  = (mcyc_q == MC_FETCH) || (mcyc_q == MC_READ);
        case (state_q)
            T1: begin
                ale_c  = mem_c;
                wreg_c = (mcyc_q == MC_FETCH) && wb_pend_q;
            end
            T2, TW: rd_c = mem_c;
            T3: begin
                rd_c   = mem_c;
                code_c = (mcyc_q == MC_FETCH);
                data_c = (mcyc_q == MC_READ);
                rreg_c = (mcyc_q == MC_READ) || ((mcyc_q == MC_IDLE) && bi_cnt_q);
            end
            // Last T-state of a register-to-register instruction: no further cycles follow.
            T4: rreg_c = !go6 && !hlt && !imm && !dad;
            T6: rreg_c = !hlt && !imm && !dad;
            default: ;
        endcase
    end

    // Outputs are gated by rst_n so they take reset values the moment reset asserts.
    assign bus.ale      = rst_n & ale_c;
    assign bus.rd_n     = ~(rst_n & rd_c);
    assign bus.enb_code = rst_n & code_c;
    assign bus.enb_data = rst_n & data_c;
    assign bus.enb_rreg = rst_n & rreg_c;
    assign bus.enb_wreg = rst_n & wreg_c;
    assign bus.t_state  = rst_n ? state_q : T1;
    assign bus.m_cycle  = rst_n ? mcyc_q : MC_FETCH;

endmodule

// File: tb/tb_core_seq.sv
// Bench for core_seq: expands each directed instruction into its expected per-cycle T/M sequence and outputs,
// drives inputs on the falling edge and compares all outputs shortly after, including async reset cases.
module tb_core_seq;
    import core_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    core_seq_if bus();

    core_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ready;
        logic [1:0] chk;
        logic       imm;
        logic       halt;
        logic [2:0] t;
        logic [1:0] m;
        logic       ale;
        logic       rd_n;
        logic       code;
        logic       data;
        logic       rreg;
        logic       wreg;
    } rec_t;

    rec_t recs[$];
    rec_t cur[$];
    rec_t exp_cur;
    rec_t rst_rec;
    bit   chk_en  = 1'b0;
    bit   prev_wb = 1'b0;

    int n_pass    = 0;
    int n_total   = 0;
    int m2_seen   = 0;
    int wreg_halt = 0;

    task automatic check(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected outputs follow directly from which T-state of which machine cycle we are in.
    function automatic rec_t mk(input logic [2:0] t, input logic [1:0] m, input logic rdy);
        rec_t r;
        logic mem;
        mem    = (m == 2'd0) || (m == 2'd1);
        r.ready = rdy;
        r.chk   = 2'b00;
        r.imm   = 1'b0;
        r.halt  = 1'b0;
        r.t     = t;
        r.m     = m;
        r.ale   = (t == T1) && mem;
        r.rd_n  = !(((t == T2) || (t == TW) || (t == T3)) && mem);
        r.code  = (t == T3) && (m == 2'd0);
        r.data  = (t == T3) && (m == 2'd1);
        r.rreg  = 1'b0;
        r.wreg  = 1'b0;
        return r;
    endfunction

    // T2, w wait states, T3 of a memory cycle; ready low until the last wait.
    task automatic push_mem(input logic [1:0] m, input int w);
        cur.push_back(mk(T2, m, w == 0));
        for (int i = 0; i < w; i++) cur.push_back(mk(TW, m, i == w - 1));
        cur.push_back(mk(T3, m, rnd()));
    endtask

    task automatic add_inst(input bit go6, input bit dad, input bit imm, input bit halt,
                            input int w1, input int w2, output int len);
        cur.delete();
        cur.push_back(mk(T1, 2'd0, rnd()));
        push_mem(2'd0, w1);
        cur.push_back(mk(T4, 2'd0, rnd()));
        if (go6) begin
            cur.push_back(mk(T5, 2'd0, rnd()));
            cur.push_back(mk(T6, 2'd0, rnd()));
        end
        if (!halt) begin
            if (imm) begin
                cur.push_back(mk(T1, 2'd1, rnd()));
                push_mem(2'd1, w2);
            end else if (dad) begin
                repeat (2) begin
                    cur.push_back(mk(T1, 2'd2, 1'b1));
                    cur.push_back(mk(T2, 2'd2, 1'b1));
                    cur.push_back(mk(T3, 2'd2, 1'b1));
                end
            end
        end
        foreach (cur[i]) begin
            cur[i].chk  = {dad, go6};
            cur[i].imm  = imm;
            cur[i].halt = halt;
        end
        cur[0].wreg             = prev_wb;
        cur[cur.size()-1].rreg  = !halt;
        prev_wb                 = !halt;
        len                     = cur.size();
        foreach (cur[i]) recs.push_back(cur[i]);
    endtask

    task automatic add_halt(input int n);
        repeat (n) recs.push_back(mk(HALT, 2'd3, rnd()));
    endtask

    task automatic play(input int n);
        rec_t r;
        for (int i = 0; i < n && recs.size() > 0; i++) begin
            r = recs.pop_front();
            @(negedge clk); #1;
            rst_n        = 1'b1;
            bus.ready    = r.ready;
            bus.chk_inst = r.chk;
            bus.op_imm   = r.imm;
            bus.op_halt  = r.halt;
            exp_cur      = r;
            chk_en       = 1'b1;
        end
    endtask

    task automatic do_reset(input int n);
        repeat (n) begin
            @(negedge clk); #1;
            rst_n     = 1'b0;
            bus.ready = rnd();
            exp_cur   = rst_rec;
            chk_en    = 1'b1;
        end
        prev_wb = 1'b0;
        recs.delete();
    endtask

    // Single compare process: every cycle with a live expectation.
    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            check("t_state",  int'(bus.t_state),  int'(exp_cur.t));
            check("m_cycle",  int'(bus.m_cycle),  int'(exp_cur.m));
            check("ale",      int'(bus.ale),      int'(exp_cur.ale));
            check("rd_n",     int'(bus.rd_n),     int'(exp_cur.rd_n));
            check("enb_code", int'(bus.enb_code), int'(exp_cur.code));
            check("enb_data", int'(bus.enb_data), int'(exp_cur.data));
            check("enb_rreg", int'(bus.enb_rreg), int'(exp_cur.rreg));
            check("enb_wreg", int'(bus.enb_wreg), int'(exp_cur.wreg));
            if (bus.m_cycle == 2'd2) m2_seen++;
            if (bus.t_state == HALT && bus.enb_wreg) wreg_halt++;
        end
    end

    initial begin
        int len;
        bus.ready    = 1'b1;
        bus.chk_inst = 2'b00;
        bus.op_imm   = 1'b0;
        bus.op_halt  = 1'b0;
        rst_rec      = mk(T1, 2'd0, 1'b1);
        rst_rec.ale  = 1'b0;

        do_reset(3);

        // Instruction lengths from the model, pinned by hand
        add_inst(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, len); check("len_mov", len, 4);
        add_inst(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, len); check("len_inx", len, 6);
        add_inst(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, len); check("len_mvi", len, 7);
        add_inst(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, len); check("len_dad", len, 10);
        add_inst(1'b0, 1'b0, 1'b0, 1'b0, 2, 0, len); check("len_mov_wait2", len, 6);
        add_inst(1'b1, 1'b0, 1'b1, 1'b0, 0, 1, len); check("len_go6_imm_wait1", len, 10);
        add_inst(1'b0, 1'b1, 1'b1, 1'b0, 0, 0, len); check("len_imm_over_dad", len, 7);
        add_inst(1'b0, 1'b1, 1'b1, 1'b1, 0, 0, len); check("len_hlt", len, 4);
        add_halt(22);
        play(recs.size());
        #3;
        check("dad_idle_cycles", m2_seen, 6);

        // Reset in the middle of HALT
        do_reset(2);

        // Reset in the middle of a wait state: T1, T2, TW, TW then abort
        add_inst(1'b0, 1'b0, 1'b0, 1'b0, 5, 0, len);
        play(4);
        do_reset(2);

        // Clean restart
        add_inst(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, len);
        add_inst(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, len);
        add_inst(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, len);
        play(recs.size());
        #3;
        chk_en = 1'b0;
        check("wreg_in_halt", wreg_halt, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/core_seq.md
# core_seq

T-state / machine-cycle sequencer for the 8085-class core. Drives the enables of the ALU/register datapath (`enb_code`, `enb_data`, `enb_rreg`, `enb_wreg`) and the bus strobes (`ale`, `rd_n`), stretching cycles with `ready`. Instruction length follows the datapath's decode hints and the external decoder's flags. Supported cycle types: opcode fetch (4 or 6 T), one immediate memory read (3 T), two bus-idle cycles for DAD (3 T each), and HALT.

## Interface
- `TSTSIZE`, 3: width of `t_state`.
- `MCYSIZE`, 2: width of `m_cycle`.
- `INSTSIZE`, 2: width of `chk_inst`; bit 0 = GO6, bit 1 = DAD.
- `clk` in 1: core clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ready` in 1: memory ready; sampled at the end of T2 and TW.
- `chk_inst` in INSTSIZE: decode hints from the datapath; valid from T4 of M1.
- `op_imm` in 1: current opcode needs one immediate byte; valid from T4 of M1.
- `op_halt` in 1: current opcode is HLT; valid from T4 of M1.
- `ale` out 1: address latch enable.
- `rd_n` out 1: read strobe, active-low.
- `enb_code` out 1: load instruction register.
- `enb_data` out 1: load temp data register.
- `enb_rreg` out 1: register-file read enable.
- `enb_wreg` out 1: register-file write enable.
- `t_state` out TSTSIZE: current T-state code.
- `m_cycle` out MCYSIZE: 0 = opcode fetch, 1 = memory read, 2 = bus idle, 3 = halt.

## Operation
- States: T1, T2, TW, T3, T4, T5, T6, HALT. Registers: state, m_cycle, bi_cnt (1 bit), wb_pend.
- **Opcode fetch, M1:** T1 → T2 → (TW)* → T3 → T4 → [T5 → T6 if `chk_inst[0]`].
- **Memory read, M2:** T1 → T2 → (TW)* → T3.
- **Bus idle, BI:** T1 → T2 → T3 with no strobes; exactly two BI cycles per DAD.
- **Wait states:** at the end of T2 or TW, `ready`=0 → TW, `ready`=1 → T3.
- **At the end of T4, or T6 when GO6, in M1:**
  - `op_halt` → HALT.
  - else `op_imm` → M2 T1.
  - else `chk_inst[1]` → BI T1 with bi_cnt=0.
  - else → M1 T1 with wb_pend=1.
- **End of M2 T3:** → M1 T1, wb_pend=1.
- **End of BI T3:** bi_cnt=0 → BI T1 with bi_cnt=1; bi_cnt=1 → M1 T1 with wb_pend=1.
- **Strobes:**
  - `ale` = 1 in T1 of M1/M2.
  - `rd_n` = 0 in T2, TW, T3 of M1/M2.
- **Enables:**
  - `enb_code` = 1 in M1 T3.
  - `enb_data` = 1 in M2 T3.
  - `enb_rreg` = 1 in the last T-state of an instruction that sets wb_pend.
  - `enb_wreg` = 1 in M1 T1 when wb_pend=1; wb_pend clears at the end of that T1. The write-back overlaps the next fetch; the instruction register is not reloaded until T3.
- **HALT:** no strobes, no enables, `ready` ignored. Exit only by reset. wb_pend clears on entry, so HLT performs no write.
- Priority on simultaneous flags: `op_halt` > `op_imm` > `chk_inst[1]`. `chk_inst[0]` only adds T5/T6 and combines with any of the above.

## Timing
- **Reset values** (held while `rst_n`=0, all outputs gated by `rst_n`): `ale`=0, `rd_n`=1, all `enb_*`=0, `t_state`=T1, `m_cycle`=0, wb_pend=0, bi_cnt=0.
- The first rising edge after `rst_n` deasserts ends M1 T1, so the first cycle after release shows `ale`=1.
- Reset mid-cycle (any state, including TW or HALT) aborts immediately. A pending write-back is lost.
- **T-state counts with `ready`=1:**
  - plain 4.
  - GO6 6.
  - immediate 7.
  - GO6 + immediate 9.
  - DAD 10.
  - HLT: 4, then HALT.
- Each low-`ready` sample adds exactly one TW.
- `chk_inst`, `op_imm` and `op_halt` are sampled only on the edge that leaves T4 or T6.

## Structure
- Shared package `core_pkg`:
  - T-state codes: T1=0, T2=1, T3=2, T4=3, T5=4, T6=5, TW=6, HALT=7.
  - m_cycle codes.
  - INST_GO6 / INST_DAD bit indices.
- Single module `core_seq`, no sub-modules. State and output decode are flat combinational from the state registers.

## Test plan
- MOV B,C (0x41), `ready`=1 → 4 T-states; `enb_code` in T3; `enb_rreg` in T4; `enb_wreg` in the next T1; `rd_n` low for T2–T3 only.
- INX B (0x03), `chk_inst`=01 → T1..T6 (6 T); `enb_rreg` in T6; `enb_wreg` in the following M1 T1.
- MVI A,0x5A (0x3E), `op_imm`=1 → M1 4 T + M2 3 T; `enb_data` in M2 T3; `ale` in both T1s; `enb_wreg` in the next M1 T1.
- DAD B (0x09), `chk_inst`=10 → M1 + BI + BI = 10 T; `m_cycle`=2 for 6 cycles with `ale`=0, `rd_n`=1.
- MOV fetch with `ready`=0 for 2 samples → TW,TW between T2 and T3; `rd_n` stays low; total 6 T.
- HLT (0x76), `op_halt`=1 → HALT after T4 and stays 20+ cycles; `enb_wreg` never asserts. Assert `rst_n`=0 mid-HALT and again mid-TW → outputs take reset values at once; restart is a clean M1 T1.
